// File: rtl/bcp_sequencer_if.sv
// Handshake and memory bus bundle for the BCP sequencer.
// master: sequencer side; slave: environment side (memory, init logic,
// check units, conflict analysis and variable selection).
interface bcp_sequencer_if #(
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned CHECK_NUM = 8
);
   logic                 system_initial_signal;
   logic                 initial_finish;
   logic                 bcp_request;
   logic                 mem_finish;
   logic [DATA_W-1:0]    mem_rdata;
   logic [CHECK_NUM-1:0] bcp_finish;
   logic [CHECK_NUM-1:0] bcp_conflict;
   logic                 conflict_done;
   logic                 select_var_finish;

   logic                 initial_request;
   logic                 mem_request;
   logic                 mem_read;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    free_vec;
   logic [DATA_W-1:0]    assign_vec;
   logic [DATA_W-1:0]    clause_word;
   logic                 clause_we;
   logic                 bcp_start;
   logic                 conflict_analysis_request;
   logic                 select_var_request;
   logic                 busy;

   modport master (
      input  system_initial_signal, initial_finish, bcp_request, mem_finish,
             mem_rdata, bcp_finish, bcp_conflict, conflict_done,
             select_var_finish,
      output initial_request, mem_request, mem_read, mem_addr, free_vec,
             assign_vec, clause_word, clause_we, bcp_start,
             conflict_analysis_request, select_var_request, busy
   );

   modport slave (
      output system_initial_signal, initial_finish, bcp_request, mem_finish,
             mem_rdata, bcp_finish, bcp_conflict, conflict_done,
             select_var_finish,
      input  initial_request, mem_request, mem_read, mem_addr, free_vec,
             assign_vec, clause_word, clause_we, bcp_start,
             conflict_analysis_request, select_var_request, busy
   );
endinterface

// File: rtl/bcp_sequencer.sv
// BCP engine sequencer: INIT, fetch of free/assignment/clause words,
// parallel check collection across CHECK_NUM units, then hand-off to
// conflict analysis or variable selection.
// Optional: define BCP_TIMEOUT_EN to add a CHECK watchdog (TIMEOUT cycles)
// with a sticky timeout_err output.
module bcp_sequencer #(
   parameter int unsigned ADDR_W      = 3,
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CHECK_NUM   = 8,
   parameter int unsigned FETCH_WORDS = 4,
   parameter int unsigned TIMEOUT     = 255
) (
   input  logic clock,
   input  logic reset,
`ifdef BCP_TIMEOUT_EN
   output logic timeout_err,
`endif
   bcp_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_FETCH, S_CHECK, S_RESOLVE, S_CONFLICT, S_SELECT
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(FETCH_WORDS - 1);

   if (FETCH_WORDS < 2 || FETCH_WORDS > (1 << ADDR_W) || TIMEOUT < 1) begin : g_bad_cfg
      $error("bcp_sequencer: FETCH_WORDS must be 2..2**ADDR_W and TIMEOUT >= 1");
   end

   state_t               state_q, state_nx;
   logic [ADDR_W-1:0]    cnt_q;
   logic [CHECK_NUM-1:0] done_q;
   logic                 conf_q;
   logic [DATA_W-1:0]    free_q, assign_q;
   logic                 start_q;

`ifdef BCP_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_nx;
   end

   // Next-state decode and Moore/fetch-path outputs
   always_comb begin
      state_nx                      = state_q;
      bus.initial_request           = 1'b0;
      bus.mem_request               = 1'b0;
      bus.mem_read                  = 1'b0;
      bus.mem_addr                  = '0;
      bus.clause_word               = '0;
      bus.clause_we                 = 1'b0;
      bus.conflict_analysis_request = 1'b0;
      bus.select_var_request        = 1'b0;
      bus.busy                      = (state_q != S_IDLE);
      bus.bcp_start                 = start_q;
      bus.free_vec                  = free_q;
      bus.assign_vec                = assign_q;
      case (state_q)
         S_IDLE: begin
            if (bus.system_initial_signal) state_nx = S_INIT;
            else if (bus.bcp_request)      state_nx = S_FETCH;
         end
         S_INIT: begin
            bus.initial_request = 1'b1;
            if (bus.initial_finish) state_nx = S_IDLE;
         end
         S_FETCH: begin
            bus.mem_request = 1'b1;
            bus.mem_read    = 1'b1;
            bus.mem_addr    = cnt_q;
            if (bus.mem_finish && cnt_q > ADDR_W'(1)) begin
               bus.clause_we   = 1'b1;
               bus.clause_word = bus.mem_rdata;
            end
            if (bus.mem_finish && cnt_q == LAST_WORD) state_nx = S_CHECK;
         end
         S_CHECK: begin
            // Current-cycle finishes are OR-ed in so an all-at-once finish exits immediately
            if (&(done_q | bus.bcp_finish)) state_nx = S_RESOLVE;
`ifdef BCP_TIMEOUT_EN
            else if (tmo_q == TMO_W'(TIMEOUT - 1)) state_nx = S_IDLE;
`endif
         end
         S_RESOLVE: state_nx = conf_q ? S_CONFLICT : S_SELECT;
         S_CONFLICT: begin
            bus.conflict_analysis_request = 1'b1;
            if (bus.conflict_done) state_nx = S_IDLE;
         end
         S_SELECT: begin
            bus.select_var_request = 1'b1;
            if (bus.select_var_finish) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Fetch counter, latched vectors, done mask, conflict flag, start pulse
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_q    <= '0;
         done_q   <= '0;
         conf_q   <= 1'b0;
         free_q   <= '0;
         assign_q <= '0;
         start_q  <= 1'b0;
      end else begin
         start_q <= (state_q == S_FETCH) && (state_nx == S_CHECK);
         case (state_q)
            S_IDLE: begin
               if (!bus.system_initial_signal && bus.bcp_request) begin
                  cnt_q  <= '0;
                  done_q <= '0;
                  conf_q <= 1'b0;
               end
            end
            S_FETCH: begin
               if (bus.mem_finish) begin
                  if (cnt_q == '0)          free_q   <= bus.mem_rdata;
                  if (cnt_q == ADDR_W'(1))  assign_q <= bus.mem_rdata;
                  cnt_q <= cnt_q + ADDR_W'(1);
               end
            end
            S_CHECK: begin
               done_q <= done_q | bus.bcp_finish;
               conf_q <= conf_q | (|(bus.bcp_conflict & bus.bcp_finish));
            end
            default: ;
         endcase
      end
   end

`ifdef BCP_TIMEOUT_EN
   // CHECK watchdog: counter idles at zero outside CHECK; error is sticky
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q != S_CHECK) tmo_q <= '0;
         else                    tmo_q <= tmo_q + TMO_W'(1);
         if (state_q == S_CHECK && state_nx == S_IDLE) err_q <= 1'b1;
      end
   end

   assign timeout_err = err_q;
`endif

endmodule

// File: tb/tb_bcp_sequencer.sv
// Directed testbench for bcp_sequencer. Inputs change at the falling edge,
// outputs are sampled 1 time unit later (well before the next rising edge).
// Define BCP_TIMEOUT_EN to also exercise the CHECK watchdog.
module tb_bcp_sequencer;
   localparam int unsigned ADDR_W      = 3;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned CHECK_NUM   = 8;
   localparam int unsigned FETCH_WORDS = 4;
   localparam int unsigned TIMEOUT     = 10;

   // ctl = {busy, initial_request, mem_request, mem_read, bcp_start,
   //        clause_we, conflict_analysis_request, select_var_request}
   localparam logic [7:0] ST_IDLE     = 8'b0000_0000;
   localparam logic [7:0] ST_INIT     = 8'b1100_0000;
   localparam logic [7:0] ST_FETCH    = 8'b1011_0000;
   localparam logic [7:0] ST_FETCH_WE = 8'b1011_0100;
   localparam logic [7:0] ST_START    = 8'b1000_1000;
   localparam logic [7:0] ST_BUSY     = 8'b1000_0000;
   localparam logic [7:0] ST_CONF     = 8'b1000_0010;
   localparam logic [7:0] ST_SELECT   = 8'b1000_0001;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   bcp_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHECK_NUM(CHECK_NUM)) bus ();

`ifdef BCP_TIMEOUT_EN
   logic timeout_err;
`endif

   bcp_sequencer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHECK_NUM(CHECK_NUM),
      .FETCH_WORDS(FETCH_WORDS), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
`ifdef BCP_TIMEOUT_EN
      .timeout_err(timeout_err),
`endif
      .bus(bus)
   );

   always #5 clock = ~clock;

   logic [7:0] ctl;
   assign ctl = {bus.busy, bus.initial_request, bus.mem_request, bus.mem_read,
                 bus.bcp_start, bus.clause_we, bus.conflict_analysis_request,
                 bus.select_var_request};

   task automatic test_reset();
      bus.system_initial_signal = 1'b0; bus.initial_finish = 1'b0;
      bus.bcp_request = 1'b0; bus.mem_finish = 1'b0; bus.mem_rdata = '0;
      bus.bcp_finish = '0; bus.bcp_conflict = '0;
      bus.conflict_done = 1'b0; bus.select_var_finish = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL reset_held ctl got %b want %b", ctl, ST_IDLE); end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock); #1;
         n_vec++;
         if ({ctl, bus.mem_addr, bus.clause_word, bus.free_vec, bus.assign_vec} !== '0) begin
            n_err++;
            $display("FAIL reset_idle cycle %0d ctl=%b addr=%h cw=%h free=%h asg=%h want all 0",
                     i, ctl, bus.mem_addr, bus.clause_word, bus.free_vec, bus.assign_vec);
         end
      end
   endtask

   task automatic test_init_priority();
      @(negedge clock); bus.system_initial_signal = 1'b1; bus.bcp_request = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL init_req_cycle ctl got %b want %b", ctl, ST_IDLE); end
      @(negedge clock); bus.system_initial_signal = 1'b0; bus.bcp_request = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_INIT) begin n_err++; $display("FAIL init_enter ctl got %b want %b", ctl, ST_INIT); end
      repeat (2) begin
         @(negedge clock); #1;
         n_vec++;
         if (ctl !== ST_INIT) begin n_err++; $display("FAIL init_hold ctl got %b want %b", ctl, ST_INIT); end
      end
      @(negedge clock); bus.initial_finish = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_INIT) begin n_err++; $display("FAIL init_finish_cycle ctl got %b want %b", ctl, ST_INIT); end
      @(negedge clock); bus.initial_finish = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL init_exit ctl got %b want %b", ctl, ST_IDLE); end
      @(negedge clock); #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL init_no_fetch ctl got %b want %b", ctl, ST_IDLE); end
   endtask

   // mem_finish every second cycle; ends in the first CHECK cycle
   task automatic test_fetch();
      logic [7:0] ws [4];
      ws = '{8'hA5, 8'h3C, 8'h11, 8'h22};
      @(negedge clock); bus.bcp_request = 1'b1; #1;
      for (int unsigned w = 0; w < 4; w++) begin
         @(negedge clock); bus.bcp_request = 1'b0; bus.mem_finish = 1'b0; #1;
         n_vec++;
         if (ctl !== ST_FETCH || bus.mem_addr !== 3'(w)) begin
            n_err++; $display("FAIL fetch_wait w%0d ctl=%b addr=%0d want %b addr %0d", w, ctl, bus.mem_addr, ST_FETCH, w);
         end
         if (w >= 1) begin
            n_vec++;
            if (bus.free_vec !== 8'hA5) begin n_err++; $display("FAIL fetch_free got %h want a5", bus.free_vec); end
         end
         if (w >= 2) begin
            n_vec++;
            if (bus.assign_vec !== 8'h3C) begin n_err++; $display("FAIL fetch_assign got %h want 3c", bus.assign_vec); end
         end
         @(negedge clock); bus.mem_finish = 1'b1; bus.mem_rdata = ws[w]; #1;
         n_vec++;
         if (ctl !== ((w >= 2) ? ST_FETCH_WE : ST_FETCH) || bus.mem_addr !== 3'(w)) begin
            n_err++; $display("FAIL fetch_word w%0d ctl=%b addr=%0d", w, ctl, bus.mem_addr);
         end
         if (w >= 2) begin
            n_vec++;
            if (bus.clause_word !== ws[w]) begin n_err++; $display("FAIL clause_word w%0d got %h want %h", w, bus.clause_word, ws[w]); end
         end
      end
      @(negedge clock); bus.mem_finish = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_START) begin n_err++; $display("FAIL bcp_start ctl got %b want %b", ctl, ST_START); end
   endtask

   // Enters in first CHECK cycle; unit 0 at +1, units 1..7 at +4
   task automatic test_check_staggered();
      @(negedge clock); bus.bcp_finish = 8'h01; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL chk_p1 ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.bcp_finish = 8'h00; bus.bcp_conflict = 8'hFF;
      bus.mem_finish = 1'b1; bus.mem_rdata = 8'hFF; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL chk_p2_memfin ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.bcp_conflict = 8'h00; bus.mem_finish = 1'b0;
      bus.bcp_request = 1'b1; bus.system_initial_signal = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL chk_p3 ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.bcp_request = 1'b0; bus.system_initial_signal = 1'b0; bus.bcp_finish = 8'hFE; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL chk_p4 ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.bcp_finish = 8'h00; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL chk_resolve ctl got %b want %b", ctl, ST_BUSY); end
      n_vec++;
      if (bus.free_vec !== 8'hA5) begin n_err++; $display("FAIL free_hold got %h want a5", bus.free_vec); end
      repeat (2) begin
         @(negedge clock); #1;
         n_vec++;
         if (ctl !== ST_SELECT) begin n_err++; $display("FAIL chk_select ctl got %b want %b", ctl, ST_SELECT); end
      end
      @(negedge clock); bus.select_var_finish = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_SELECT) begin n_err++; $display("FAIL sel_finish_cycle ctl got %b want %b", ctl, ST_SELECT); end
      @(negedge clock); bus.select_var_finish = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL sel_exit ctl got %b want %b", ctl, ST_IDLE); end
      @(negedge clock); #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL no_queue ctl got %b want %b", ctl, ST_IDLE); end
   endtask

   // mem_finish held high across all words; ends in the first CHECK cycle
   task automatic run_fetch(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3);
      logic [7:0] ws [4];
      ws = '{w0, w1, w2, w3};
      @(negedge clock); bus.bcp_request = 1'b1; #1;
      for (int unsigned w = 0; w < 4; w++) begin
         @(negedge clock); bus.bcp_request = 1'b0; bus.mem_finish = 1'b1; bus.mem_rdata = ws[w]; #1;
         n_vec++;
         if (ctl !== ((w >= 2) ? ST_FETCH_WE : ST_FETCH) || bus.mem_addr !== 3'(w)) begin
            n_err++; $display("FAIL burst_word w%0d ctl=%b addr=%0d", w, ctl, bus.mem_addr);
         end
      end
      @(negedge clock); bus.mem_finish = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_START) begin n_err++; $display("FAIL burst_start ctl got %b want %b", ctl, ST_START); end
      n_vec++;
      if (bus.free_vec !== w0 || bus.assign_vec !== w1) begin
         n_err++; $display("FAIL burst_vecs free=%h asg=%h want %h %h", bus.free_vec, bus.assign_vec, w0, w1);
      end
   endtask

   task automatic test_conflict();
      run_fetch(8'h0F, 8'hF0, 8'h55, 8'hAA);
      bus.bcp_finish = 8'h20; bus.bcp_conflict = 8'h20;
      @(negedge clock); bus.bcp_finish = 8'hDF; bus.bcp_conflict = 8'h00; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL conf_check ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.bcp_finish = 8'h00; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL conf_resolve ctl got %b want %b", ctl, ST_BUSY); end
      repeat (3) begin
         @(negedge clock); #1;
         n_vec++;
         if (ctl !== ST_CONF) begin n_err++; $display("FAIL conf_hold ctl got %b want %b", ctl, ST_CONF); end
      end
      @(negedge clock); bus.conflict_done = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_CONF) begin n_err++; $display("FAIL conf_done_cycle ctl got %b want %b", ctl, ST_CONF); end
      @(negedge clock); bus.conflict_done = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL conf_exit ctl got %b want %b", ctl, ST_IDLE); end
   endtask

   // All units finish in the first CHECK cycle; stale conflict must not carry over
   task automatic test_back_to_back();
      run_fetch(8'h11, 8'h22, 8'h33, 8'h44);
      bus.bcp_finish = 8'hFF;
      @(negedge clock); bus.bcp_finish = 8'h00; #1;
      n_vec++;
      if (ctl !== ST_BUSY) begin n_err++; $display("FAIL b2b_resolve ctl got %b want %b", ctl, ST_BUSY); end
      @(negedge clock); bus.select_var_finish = 1'b1; #1;
      n_vec++;
      if (ctl !== ST_SELECT) begin n_err++; $display("FAIL b2b_select ctl got %b want %b", ctl, ST_SELECT); end
      @(negedge clock); bus.select_var_finish = 1'b0; #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL b2b_exit ctl got %b want %b", ctl, ST_IDLE); end
   endtask

   task automatic test_reset_mid();
      @(negedge clock); bus.bcp_request = 1'b1;
      @(negedge clock); bus.bcp_request = 1'b0; bus.mem_finish = 1'b1; bus.mem_rdata = 8'h77;
      @(negedge clock); bus.mem_rdata = 8'h88; #1;
      n_vec++;
      if (bus.mem_addr !== 3'd1 || bus.free_vec !== 8'h77) begin
         n_err++; $display("FAIL mid_pre addr=%0d free=%h want 1 77", bus.mem_addr, bus.free_vec);
      end
      #1 reset = 1'b0; #1;
      n_vec++;
      if ({ctl, bus.mem_addr, bus.free_vec, bus.assign_vec} !== '0) begin
         n_err++; $display("FAIL mid_reset ctl=%b addr=%0d free=%h asg=%h want all 0",
                           ctl, bus.mem_addr, bus.free_vec, bus.assign_vec);
      end
      @(negedge clock); bus.mem_finish = 1'b0; reset = 1'b1;
      @(negedge clock); #1;
      n_vec++;
      if (ctl !== ST_IDLE) begin n_err++; $display("FAIL mid_after ctl got %b want %b", ctl, ST_IDLE); end
   endtask

`ifdef BCP_TIMEOUT_EN
   task automatic test_timeout();
      run_fetch(8'h01, 8'h02, 8'h03, 8'h04);
      bus.bcp_finish = 8'h7F;
      for (int i = 1; i < 10; i++) begin
         @(negedge clock); #1;
         n_vec++;
         if (ctl !== ST_BUSY || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL tmo_wait cycle %0d ctl=%b err=%b want %b 0", i, ctl, timeout_err, ST_BUSY);
         end
      end
      @(negedge clock); #1;
      n_vec++;
      if (ctl !== ST_IDLE || timeout_err !== 1'b1) begin
         n_err++; $display("FAIL tmo_fire ctl=%b err=%b want %b 1", ctl, timeout_err, ST_IDLE);
      end
      @(negedge clock); bus.bcp_finish = 8'h00; #1;
      n_vec++;
      if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky got %b want 1", timeout_err); end
      reset = 1'b0; #1;
      n_vec++;
      if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_reset got %b want 0", timeout_err); end
      @(negedge clock); reset = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_init_priority();
      test_fetch();
      test_check_staggered();
      test_conflict();
      test_back_to_back();
      test_reset_mid();
`ifdef BCP_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
